// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller for a byte-addressed, big-endian RAM.
// A small window of byte addresses is shadowed by 8-bit GPIO output registers.
// A request is accepted in IDLE. Its response is registered and held in RESP
// until the consumer takes it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data, right-aligned and zero-extended
//   rsp_err           request rejected
//   gpio              GPIO channel i on bits [8i+7:8i]
//   err_count         saturating count of rejected requests
//
// state | meaning
// IDLE  | ready for a request, no response pending
// RESP  | response registered, waiting for rsp_ready
module data_mem_ctrl #(
   parameter int DEPTH_BYTES = 2048,
   parameter int GPIO_BASE   = 'ha0,
   parameter int GPIO_CH     = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic [8*GPIO_CH-1:0] gpio,
   output logic [7:0]           err_count
);

   localparam int AW = $clog2(DEPTH_BYTES);

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  mem [DEPTH_BYTES] = '{default: 8'h00};
   logic [2:0]  nbytes;
   logic [32:0] last_addr;
   logic        reject, accept, wr_en;
   logic [31:0] lane_addr [4];
   logic [3:0]  lane_act, lane_gpio;
   logic [7:0]  lane_rd [4];
   logic [7:0]  lane_wd [4];
   logic [31:0] load_data;

   // Lane k covers byte address req_addr+k. Lane 0 is the most significant byte.
   always_comb begin
      nbytes   = 3'd4;
      lane_act = 4'b1111;
      lane_wd  = '{req_wdata[31:24], req_wdata[23:16], req_wdata[15:8], req_wdata[7:0]};
      case (req_size)
         2'b00: begin
            nbytes   = 3'd1;
            lane_act = 4'b0001;
            lane_wd  = '{req_wdata[7:0], 8'h00, 8'h00, 8'h00};
         end
         2'b01: begin
            nbytes   = 3'd2;
            lane_act = 4'b0011;
            lane_wd  = '{req_wdata[15:8], req_wdata[7:0], 8'h00, 8'h00};
         end
         default: ;
      endcase
   end

   // The last byte address is formed in 33 bits so that a high address cannot wrap into range.
   always_comb begin
      last_addr = {1'b0, req_addr} + 33'(nbytes) - 33'd1;
      reject    = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (last_addr >= 33'(DEPTH_BYTES));
   end

   // Each lane routes to GPIO or RAM on its own, so an access can straddle both.
   always_comb begin
      load_data = '0;
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = req_addr + 32'(k);
         lane_gpio[k] = 1'b0;
         lane_rd[k]   = mem[lane_addr[k][AW-1:0]];
         for (int c = 0; c < GPIO_CH; c++) begin
            if (lane_addr[k] == 32'(GPIO_BASE + c)) begin
               lane_gpio[k] = 1'b1;
               lane_rd[k]   = gpio[8*c +: 8];
            end
         end
         if (lane_act[k]) begin
            load_data = {load_data[23:0], lane_rd[k]};
         end
      end
   end

   assign accept = (state == IDLE) && req_valid;
   assign wr_en  = accept && req_write && !reject;

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         err_count <= '0;
         gpio      <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            rsp_err   <= reject;
            rsp_rdata <= (reject || req_write) ? 32'd0 : load_data;
            if (reject && err_count != 8'hff) err_count <= err_count + 8'd1;
         end
         if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
               for (int c = 0; c < GPIO_CH; c++) begin
                  if (lane_act[k] && lane_addr[k] == 32'(GPIO_BASE + c)) gpio[8*c +: 8] <= lane_wd[k];
               end
            end
         end
      end
   end

   // The RAM has no reset. Stores are blocked while reset is asserted.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_act[k] && !lane_gpio[k]) mem[lane_addr[k][AW-1:0]] <= lane_wd[k];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

   localparam int DEPTH = 2048;
   localparam int BASE  = 'ha0;
   localparam int CH    = 1;

   logic          clk, rst_n;
   logic          req_valid, req_ready, req_write;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [31:0]   rsp_rdata;
   logic [8*CH-1:0] gpio;
   logic [7:0]    err_count;

   data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .GPIO_BASE(BASE), .GPIO_CH(CH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .gpio(gpio), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  m_mem [DEPTH];
   logic [7:0]  m_gpio [CH];
   int          m_err;
   int          n_pass, n_total, n_fail;
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] gpio_exp();
      logic [31:0] v = 0;
      for (int c = CH - 1; c >= 0; c--) v = v * 256 + 32'(m_gpio[c]);
      return v;
   endfunction

   function automatic logic [7:0] rd_byte(input longint a);
      if (a >= BASE && a < BASE + CH) return m_gpio[a - BASE];
      return m_mem[a];
   endfunction

   // Reference model. It applies one request and returns the expected response.
   task automatic model(input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] er, output bit ee);
      int     n;
      longint ad;
      logic [7:0] b;
      n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      ee = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)
        || (longint'(a) + n - 1 >= DEPTH);
      er = 0;
      if (ee) begin
         if (m_err < 255) m_err++;
         return;
      end
      for (int k = 0; k < n; k++) begin
         ad = longint'(a) + k;
         if (w) begin
            b = 8'((wd >> (8 * (n - 1 - k))) & 32'hff);
            if (ad >= BASE && ad < BASE + CH) m_gpio[ad - BASE] = b;
            else m_mem[ad] = b;
         end else begin
            er = er * 256 + 32'(rd_byte(ad));
         end
      end
   endtask

   task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] er, output bit ee);
      int t;
      check("req_ready_idle", 32'(req_ready), 1);
      model(w, sz, a, wd, er, ee);
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      t = 0;
      while (!rsp_valid && t < 4) begin
         @(negedge clk);
         t++;
      end
      last_rdata = rsp_rdata;
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_rdata", rsp_rdata, er);
      check("rsp_err", 32'(rsp_err), 32'(ee));
      check("err_count", 32'(err_count), m_err);
      check("gpio", 32'(gpio), gpio_exp());
   endtask

   task automatic txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int hold);
      logic [31:0] er;
      bit          ee;
      issue(w, sz, a, wd, er, ee);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
         req_addr = 32'($urandom_range(0, 255)); req_wdata = $urandom;
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 1);
         check("hold_rdata", rsp_rdata, er);
         check("hold_ready", 32'(req_ready), 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 0);
      check("gpio_after", 32'(gpio), gpio_exp());
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(BASE - 8, BASE + 8));
         1: return 32'($urandom_range('h100, 'h10f));
         2: return 32'($urandom_range(DEPTH - 8, DEPTH + 3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] er;
      bit          ee;
      n_pass = 0; n_total = 0; n_fail = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      for (int c = 0; c < CH; c++) m_gpio[c] = 8'h00;
      m_err = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", 32'(rsp_err), 0);
      check("rst_gpio", 32'(gpio), 0);
      check("rst_err_count", 32'(err_count), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // The first request is driven on the same negedge as the reset release.
      txn(1, 2'b10, 32'h100, 32'hDEADBEEF, 0);
      txn(0, 2'b00, 32'h101, 0, 0);
      check("byte_load_ad", last_rdata, 32'h000000AD);
      txn(0, 2'b01, 32'h102, 0, 0);
      check("half_load_beef", last_rdata, 32'h0000BEEF);

      txn(1, 2'b00, BASE, 32'h5A, 0);
      check("gpio_5a", 32'(gpio), 32'h5A);
      txn(0, 2'b10, BASE, 0, 0);
      check("word_gpio_load", last_rdata, 32'h5A000000);

      txn(1, 2'b01, 32'h003, 32'h1234, 0);
      txn(0, 2'b10, 32'h102, 0, 0);
      txn(0, 2'b11, 32'h100, 0, 0);
      txn(0, 2'b10, 32'(DEPTH - 2), 0, 0);
      check("err_count_4", 32'(err_count), 4);
      txn(0, 2'b10, 32'h100, 0, 0);
      check("mem_unchanged", last_rdata, 32'hDEADBEEF);

      txn(0, 2'b10, 32'h100, 0, 5);

      for (int i = 0; i < 300; i++) begin
         txn(1'($urandom), 2'($urandom), rand_addr(), $urandom, $urandom_range(0, 1));
      end

      txn(1, 2'b10, 32'h200, 32'h12345678, 0);
      txn(1, 2'b00, BASE, 32'h33, 0);
      check("gpio_33", 32'(gpio), 32'h33);
      issue(0, 2'b10, 32'h104, 0, er, ee);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_gpio", 32'(gpio), 0);
      check("midrst_req_ready", 32'(req_ready), 1);
      check("midrst_err_count", 32'(err_count), 0);
      for (int c = 0; c < CH; c++) m_gpio[c] = 8'h00;
      m_err = 0;
      @(negedge clk);
      rst_n = 1'b1;
      txn(0, 2'b10, 32'h200, 0, 0);
      check("ram_survives_rst", last_rdata, 32'h12345678);

      for (int i = 0; i < 256; i++) txn(0, 2'b11, $urandom, $urandom, 0);
      check("err_count_sat", 32'(err_count), 255);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 2048, RAM size in bytes; power of two, minimum 16.
REQ-002 SHALL have parameter GPIO_BASE, default 'ha0, byte address of GPIO channel 0.
REQ-003 SHALL have parameter GPIO_CH, default 1, number of 8-bit GPIO output channels, 1..16.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  controller can accept a request.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_rdata  output  32  load data, right-aligned and zero-extended.
REQ-016 rsp_err  output  1  request rejected.
REQ-017 gpio  output  8*GPIO_CH  channel i on bits [8i+7:8i].
REQ-018 err_count  output  8  saturating count of rejected requests.

Function
REQ-019 Two-state FSM: IDLE has req_ready=1, rsp_valid=0; RESP has req_ready=0, rsp_valid=1.
REQ-020 IDLE -> RESP on the edge where req_valid=1 (accept); RESP -> IDLE on the edge where rsp_ready=1. No back-to-back accept in the same cycle as the response handshake; peak throughput is one request per 2 cycles.
REQ-021 rsp_rdata, rsp_err are registered at accept and SHALL hold stable while rsp_valid=1.
REQ-022 Byte order is big-endian: the byte at addr is most significant.
REQ-023 Word load SHALL return {m[a],m[a+1],m[a+2],m[a+3]}.
REQ-024 Half load SHALL return {16'b0,m[a],m[a+1]}.
REQ-025 Byte load SHALL return {24'b0,m[a]}.
REQ-026 Word store SHALL write wdata[31:24..7:0] to a..a+3.
REQ-027 Half store SHALL write wdata[15:8] to a and wdata[7:0] to a+1.
REQ-028 Byte store SHALL write wdata[7:0] to a.
REQ-029 Stores SHALL commit on the accept edge. A store response carries rsp_rdata=0.
REQ-030 Each byte address independently routes to GPIO channel (addr-GPIO_BASE) if GPIO_BASE <= addr < GPIO_BASE+GPIO_CH; otherwise it routes to RAM. GPIO shadows RAM at those addresses.
REQ-031 Loads of GPIO bytes SHALL return the current channel register value.
REQ-032 The request SHALL be rejected if any of the following holds:
- req_size=11;
- half with addr[0]=1;
- word with addr[1:0]!=0;
- last byte address >= DEPTH_BYTES, computed in 33 bits so there is no wrap-around.
REQ-033 A rejected request SHALL set rsp_err=1 and rsp_rdata=0, modify no RAM or GPIO, and increment err_count, saturating at 255.
REQ-034 A request accepted without rejection SHALL give rsp_err=0.
REQ-035 A load to the same address as the preceding store SHALL return the stored data.
REQ-036 req_* inputs are ignored while in RESP.
REQ-037 RAM contents SHALL initialise to all zero at time zero and are not affected by reset.

Reset
REQ-038 While rst_n=0, asynchronously and at once:
- state = IDLE, req_ready = 1, rsp_valid = 0;
- rsp_rdata = 0, rsp_err = 0;
- gpio = 0, err_count = 0.
REQ-039 Reset asserted while in RESP SHALL drop the pending response and leave RAM as already written.
REQ-040 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-041 Word store 0xDEADBEEF at 0x100, then byte load at 0x101 -> rsp_rdata=0x000000AD, rsp_err=0; half load at 0x102 -> 0x0000BEEF.
REQ-042 Byte store 0x5A at GPIO_BASE with GPIO_CH=1 -> gpio=0x5A the cycle after accept; RAM byte at 0xa0 unchanged. Word load at 0xa0 -> 0x5A000000.
REQ-043 Half store at 0x003, word load at 0x102, size=11, and word load at DEPTH_BYTES-2 -> each gives rsp_err=1 with no memory change; err_count=4.
REQ-044 Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stay constant, req_ready=0, and a new req_valid is ignored.
REQ-045 Assert rst_n=0 mid-RESP after storing gpio=0x33 -> rsp_valid=0 and gpio=0 immediately; a later load of the stored RAM address returns the pre-reset data.
REQ-046 Drive 256 rejected requests -> err_count stays at 255.
